pll_drp_reconfig_ctrl: RTL and testbench
========================================

Name: pll_drp_reconfig_ctrl

Overview:
- Sequences runtime reconfiguration of the 7-series MMCM wrapper's DRP port through its 64-bit reconfig_to_pll / reconfig_from_pll buses. Typical use: switching NES video/CPU clock sets.
- A requester loads a small table of {address, data, mask} entries, then pulses start.
- The block holds the MMCM in reset and performs a read-modify-write per entry.
- It then releases reset, waits for lock, and reports done or error.

Parameters:
- DEPTH, 8: number of table entries (power of two, 2..32).
- DRDY_TIMEOUT, 255: cycles to wait for drdy after each DRP access.
- LOCK_TIMEOUT, 65535: cycles to wait for locked after reset release.

Ports:
- refclk  in  1: controller clock. Also forwarded as the DRP clock.
- rst  in  1: synchronous, active-high reset.
- cfg_wr  in  1: table write strobe. Ignored while busy.
- cfg_idx  in  $clog2(DEPTH): table entry index.
- cfg_addr  in  7: DRP register address.
- cfg_data  in  16: new bit values.
- cfg_mask  in  16: 1 = keep existing bit, 0 = take cfg_data bit.
- start  in  1: begin sequence. Ignored while busy.
- count  in  $clog2(DEPTH)+1: entries to apply, from 0. Sampled on start; values >DEPTH are clamped to DEPTH.
- busy  out  1: high from the cycle after an accepted start until done.
- done  out  1: one-cycle pulse at end of sequence (success or error).
- error  out  1: valid with done; held until the next accepted start.
- err_code  out  2: 0 none, 1 drdy timeout, 2 lock timeout. Held like error.
- reconfig_to_pll  out  64: packed DRP bus to the MMCM wrapper.
- reconfig_from_pll  in  64: packed DRP response from the MMCM wrapper.

Behaviour:
- Packing of reconfig_to_pll:
  - [15:0] din, [22:16] daddr, [23] den, [24] dwe, [25] rst_mmcm.
  - [26] = refclk, passed through combinationally (not registered).
  - [63:27] = 0.
- Unpacking of reconfig_from_pll: [15:0] dout, [16] drdy, [17] locked. Other bits are ignored.
- Reset values: busy, done, error, err_code, din, daddr, den, dwe and rst_mmcm are all 0; FSM goes to IDLE. Table contents are not cleared.
- Table write: cfg_wr in IDLE writes entry cfg_idx on that clock edge.
- FSM, all outputs registered:
  - IDLE: start with count==0 → DONE directly. No DRP traffic, no rst_mmcm.
  - IDLE: start with count>0 → latch count; idx=0; busy=1; go to ASSERT_RST.
  - ASSERT_RST: rst_mmcm=1, held through WAIT_WR of the last entry → READ.
  - READ: den=1, dwe=0, daddr=table[idx].addr for exactly one cycle → WAIT_RD.
  - WAIT_RD: on drdy, capture dout → WRITE.
  - WRITE: den=1, dwe=1 for one cycle. Same daddr; din=(dout_cap & mask) | (data & ~mask) → WAIT_WR.
  - WAIT_WR: on drdy → NEXT.
  - NEXT: if idx==count-1 → RELEASE, else idx+1 → READ.
  - RELEASE: rst_mmcm=0 → WAIT_LOCK.
  - WAIT_LOCK: on locked==1 → DONE.
  - DONE: done=1 for one cycle; busy=0 in the same cycle → IDLE.
- den and dwe are never high for more than one consecutive cycle. At most one DRP transaction is outstanding.
- Timeout counters:
  - Reset on entry to WAIT_RD, WAIT_WR and WAIT_LOCK.
  - In WAIT_RD/WAIT_WR, if drdy is not seen within DRDY_TIMEOUT cycles: error=1, err_code=1, rst_mmcm=0 → DONE. Remaining entries are skipped.
  - In WAIT_LOCK, if locked is not seen within LOCK_TIMEOUT cycles: error=1, err_code=2 → DONE.
- drdy arriving in the same cycle the timeout expires counts as success.
- Any drdy outside WAIT_RD/WAIT_WR is ignored.
- locked may be high before RELEASE; only its level in WAIT_LOCK matters. locked seen in the first WAIT_LOCK cycle gives done 2 cycles after RELEASE.
- rst asserted mid-sequence: the next clock edge forces IDLE and reset values, including rst_mmcm=0 and den=0. No done pulse.
- Accepted start clears error and err_code.
- Minimum latency for 1 entry with 1-cycle drdy and immediate lock: start to done = 9 cycles.

Test Plan:
- Single RMW: load entry 0 = {addr 0x08, data 0x1234, mask 0xF000}; DRP model returns dout 0xABCD after 1 cycle; start count=1. Required:
  - One read then one write to 0x08 with din=0xA234.
  - rst_mmcm high from read through write drdy.
  - done after lock, error=0.
- Multi-entry: 3 entries, drdy latency 3 → reads/writes in idx order 0, 1, 2; den pulses exactly 6, each 1 cycle wide.
- count=0 start → done one cycle later; no den and no rst_mmcm activity.
- drdy never returns on the second entry's read → after DRDY_TIMEOUT cycles: error=1, err_code=1, rst_mmcm=0, done pulse, third entry untouched.
- locked held low → done with err_code=2 after LOCK_TIMEOUT cycles in WAIT_LOCK. A following start clears error.
- rst pulsed during WAIT_WR → next cycle: rst_mmcm=0, den=0, busy=0, no done. cfg_wr/start issued while busy are ignored (table unchanged, no restart).

Source files
------------

// File: rtl/pll_drp_reconfig_ctrl.sv
// ---------------------------------------------------------------------------
// pll_drp_reconfig_ctrl
//
// Purpose:
//   Applies a small table of read-modify-write operations to an MMCM through
//   its DRP port. The MMCM is held in reset for the whole sequence, then
//   released, and the controller waits for lock. It finishes with a one-cycle
//   done pulse and an error code.
//
// Ports:
//   refclk_i            controller clock, also forwarded as the DRP clock
//   rst_i               synchronous active-high reset
//   cfg_wr_i            table write strobe (only honoured while idle)
//   cfg_idx_i           table entry index
//   cfg_addr_i          DRP register address for the entry
//   cfg_data_i          new bit values for the entry
//   cfg_mask_i          1 = keep existing bit, 0 = take cfg_data bit
//   start_i             begin a sequence (only honoured while idle)
//   count_i             number of entries to apply, clamped to DEPTH
//   busy_o              sequence in progress
//   done_o              one-cycle end-of-sequence pulse
//   error_o             sequence failed, held until the next accepted start
//   err_code_o          0 none, 1 drdy timeout, 2 lock timeout
//   reconfig_to_pll_o   packed DRP request bus to the MMCM wrapper
//   reconfig_from_pll_i packed DRP response bus from the MMCM wrapper
// ---------------------------------------------------------------------------
module pll_drp_reconfig_ctrl #(
    parameter int DEPTH        = 8,
    parameter int DRDY_TIMEOUT = 255,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic                     refclk_i,
    input  logic                     rst_i,
    input  logic                     cfg_wr_i,
    input  logic [$clog2(DEPTH)-1:0] cfg_idx_i,
    input  logic [6:0]               cfg_addr_i,
    input  logic [15:0]              cfg_data_i,
    input  logic [15:0]              cfg_mask_i,
    input  logic                     start_i,
    input  logic [$clog2(DEPTH):0]   count_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     error_o,
    output logic [1:0]               err_code_o,
    output logic [63:0]              reconfig_to_pll_o,
    input  logic [63:0]              reconfig_from_pll_i
);

    localparam int IW   = $clog2(DEPTH);
    localparam int CW   = IW + 1;
    localparam int TMAX = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] DRDY_LAST = TW'(DRDY_TIMEOUT - 1);
    localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ASSERT_RST, S_READ, S_WAIT_RD, S_WRITE,
        S_WAIT_WR, S_NEXT, S_RELEASE, S_WAIT_LOCK, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   last_q, last_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [15:0]     dout_cap_q, dout_cap_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic [1:0]      err_code_q, err_code_d;
    logic [15:0]     din_q, din_d;
    logic [6:0]      daddr_q, daddr_d;
    logic            den_q, den_d;
    logic            dwe_q, dwe_d;
    logic            rst_mmcm_q, rst_mmcm_d;

    logic [6:0]      tbl_addr_q [DEPTH];
    logic [15:0]     tbl_data_q [DEPTH];
    logic [15:0]     tbl_mask_q [DEPTH];

    logic [15:0]     drp_dout;
    logic            drp_drdy;
    logic            pll_locked;
    logic            drdy_expired;
    logic            lock_expired;
    logic [CW-1:0]   count_clamped;
    logic            unused_from_pll;

    assign drp_dout        = reconfig_from_pll_i[15:0];
    assign drp_drdy        = reconfig_from_pll_i[16];
    assign pll_locked      = reconfig_from_pll_i[17];
    assign unused_from_pll = ^reconfig_from_pll_i[63:18];

    assign drdy_expired  = (timer_q == DRDY_LAST);
    assign lock_expired  = (timer_q == LOCK_LAST);
    assign count_clamped = (count_i > CW'(DEPTH)) ? CW'(DEPTH) : count_i;

    // Table storage has no reset so a loaded configuration survives a
    // controller reset; writes are only accepted while the FSM is idle.
    always_ff @(posedge refclk_i) begin
        if (cfg_wr_i && state_q == S_IDLE) begin
            tbl_addr_q[cfg_idx_i] <= cfg_addr_i;
            tbl_data_q[cfg_idx_i] <= cfg_data_i;
            tbl_mask_q[cfg_idx_i] <= cfg_mask_i;
        end
    end

    // State register together with every registered output and datapath reg.
    always_ff @(posedge refclk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            last_q     <= '0;
            timer_q    <= '0;
            dout_cap_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= 2'd0;
            din_q      <= '0;
            daddr_q    <= '0;
            den_q      <= 1'b0;
            dwe_q      <= 1'b0;
            rst_mmcm_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            timer_q    <= timer_d;
            dout_cap_q <= dout_cap_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
            din_q      <= din_d;
            daddr_q    <= daddr_d;
            den_q      <= den_d;
            dwe_q      <= dwe_d;
            rst_mmcm_q <= rst_mmcm_d;
        end
    end

    // Next-state logic. A drdy or locked seen in the expiry cycle wins over
    // the timeout, so it is tested first.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:       if (start_i) state_d = (count_i == '0) ? S_DONE : S_ASSERT_RST;
            S_ASSERT_RST: state_d = S_READ;
            S_READ:       state_d = S_WAIT_RD;
            S_WAIT_RD:    if (drp_drdy) state_d = S_WRITE;
                          else if (drdy_expired) state_d = S_DONE;
            S_WRITE:      state_d = S_WAIT_WR;
            S_WAIT_WR:    if (drp_drdy) state_d = S_NEXT;
                          else if (drdy_expired) state_d = S_DONE;
            S_NEXT:       state_d = (idx_q == last_q) ? S_RELEASE : S_READ;
            S_RELEASE:    state_d = S_WAIT_LOCK;
            S_WAIT_LOCK:  if (pll_locked || lock_expired) state_d = S_DONE;
            S_DONE:       state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    // Output logic: every output register is loaded from the state being
    // entered, so the DRP strobes line up exactly with READ/WRITE and the
    // MMCM reset drops on the same edge that enters RELEASE or DONE.
    always_comb begin
        idx_d      = idx_q;
        last_d     = last_q;
        dout_cap_d = dout_cap_q;
        error_d    = error_q;
        err_code_d = err_code_q;
        daddr_d    = daddr_q;
        din_d      = din_q;
        timer_d    = (state_d != state_q) ? '0 : timer_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    error_d    = 1'b0;
                    err_code_d = 2'd0;
                    idx_d      = '0;
                    last_d     = IW'(count_clamped - 1'b1);
                end
            end
            S_WAIT_RD: begin
                if (drp_drdy) begin
                    dout_cap_d = drp_dout;
                end else if (drdy_expired) begin
                    error_d    = 1'b1;
                    err_code_d = 2'd1;
                end
            end
            S_WAIT_WR: begin
                if (!drp_drdy && drdy_expired) begin
                    error_d    = 1'b1;
                    err_code_d = 2'd1;
                end
            end
            S_NEXT: begin
                if (state_d == S_READ) idx_d = idx_q + 1'b1;
            end
            S_WAIT_LOCK: begin
                if (!pll_locked && lock_expired) begin
                    error_d    = 1'b1;
                    err_code_d = 2'd2;
                end
            end
            default: ;
        endcase

        busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
        den_d      = (state_d == S_READ) || (state_d == S_WRITE);
        dwe_d      = (state_d == S_WRITE);
        rst_mmcm_d = (state_d == S_ASSERT_RST) || (state_d == S_READ) ||
                     (state_d == S_WAIT_RD)    || (state_d == S_WRITE) ||
                     (state_d == S_WAIT_WR)    || (state_d == S_NEXT);

        if (state_d == S_READ) daddr_d = tbl_addr_q[idx_d];
        if (state_d == S_WRITE) begin
            din_d = (dout_cap_d & tbl_mask_q[idx_q]) |
                    (tbl_data_q[idx_q] & ~tbl_mask_q[idx_q]);
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign error_o    = error_q;
    assign err_code_o = err_code_q;

    // The DRP clock bit is the controller clock itself, not a registered copy.
    assign reconfig_to_pll_o = {37'd0, refclk_i, rst_mmcm_q, dwe_q, den_q, daddr_q, din_q};

endmodule

// File: tb/tb_pll_drp_reconfig_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pll_drp_reconfig_ctrl
//
// Purpose:
//   Self-checking bench for pll_drp_reconfig_ctrl. A DRP slave model with a
//   register memory answers reads and writes, the expected transaction list
//   is derived from the loaded table, and a per-cycle process checks the bus
//   rules. Small timeouts keep the run short.
// ---------------------------------------------------------------------------
module tb_pll_drp_reconfig_ctrl;

    localparam int DEPTH   = 8;
    localparam int DRDY_TO = 20;
    localparam int LOCK_TO = 50;

    typedef struct {
        logic        we;
        logic [6:0]  addr;
        logic [15:0] din;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfgWr;
    logic [2:0]  cfgIdx;
    logic [6:0]  cfgAddr;
    logic [15:0] cfgData;
    logic [15:0] cfgMask;
    logic        start;
    logic [3:0]  count;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  errCode;
    logic [63:0] toPll;
    logic [63:0] fromPll;

    logic        drdyBit   = 1'b0;
    logic        lockedBit = 1'b0;
    logic [15:0] doutVal   = 16'h0;

    int assertCount = 0;
    int failCount   = 0;
    int cyc         = 0;

    logic [6:0]  tbAddr [DEPTH];
    logic [15:0] tbData [DEPTH];
    logic [15:0] tbMask [DEPTH];
    logic [15:0] mem     [128];
    logic [15:0] memSnap [128];

    txn_t txnLog[$];
    txn_t expTxns[$];

    int          drpLatency = 1;
    int          dropTxn    = -1;
    int          pend       = 0;
    logic        pendDrop   = 1'b0;
    logic [15:0] pendData   = 16'h0;

    logic        prevDen   = 1'b0;
    logic        rstmSeen  = 1'b0;
    int          doneCount = 0;
    int          doneCyc   = 0;
    logic        doneErr   = 1'b0;
    logic [1:0]  doneCode  = 2'd0;
    logic        doneRstm  = 1'b0;
    int          startCyc  = 0;
    int          baseDone  = 0;

    assign fromPll = {46'd0, lockedBit, drdyBit, doutVal};

    pll_drp_reconfig_ctrl #(
        .DEPTH        (DEPTH),
        .DRDY_TIMEOUT (DRDY_TO),
        .LOCK_TIMEOUT (LOCK_TO)
    ) dut (
        .refclk_i            (clk),
        .rst_i               (rst),
        .cfg_wr_i            (cfgWr),
        .cfg_idx_i           (cfgIdx),
        .cfg_addr_i          (cfgAddr),
        .cfg_data_i          (cfgData),
        .cfg_mask_i          (cfgMask),
        .start_i             (start),
        .count_i             (count),
        .busy_o              (busy),
        .done_o              (done),
        .error_o             (error),
        .err_code_o          (errCode),
        .reconfig_to_pll_o   (toPll),
        .reconfig_from_pll_i (fromPll)
    );

    // Free-running clock and a cycle counter used for latency measurements.
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // Hard stop in case something wedges the run completely.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
        end
    endtask

    // DRP slave model: logs every strobe, keeps a register memory and answers
    // drdyLatency cycles later, optionally never answering one transaction.
    always @(negedge clk) begin
        txn_t t;
        drdyBit = 1'b0;
        if (rst) begin
            pend = 0;
        end else begin
            if (pend > 0) begin
                pend = pend - 1;
                if (pend == 0 && !pendDrop) begin
                    drdyBit = 1'b1;
                    doutVal = pendData;
                end
            end
            if (toPll[23]) begin
                t.we   = toPll[24];
                t.addr = toPll[22:16];
                t.din  = toPll[15:0];
                txnLog.push_back(t);
                if (t.we) mem[t.addr] = t.din;
                else pendData = mem[t.addr];
                pend     = drpLatency;
                pendDrop = ((txnLog.size() - 1) == dropTxn);
            end
        end
    end

    // Per-cycle rule checks and done bookkeeping.
    always begin
        @(posedge clk); #1;
        checkOutput("refclk_bit_high", toPll[26], 1);
        @(negedge clk); #1;
        checkOutput("refclk_bit_low", toPll[26], 0);
        checkOutput("upper_bits_zero", toPll[63:27], 0);
        checkOutput("den_single_cycle", toPll[23] & prevDen, 0);
        checkOutput("dwe_without_den", toPll[24] & ~toPll[23], 0);
        checkOutput("den_without_rst_mmcm", toPll[23] & ~toPll[25], 0);
        checkOutput("done_with_busy", done & busy, 0);
        if (drdyBit) checkOutput("rst_mmcm_at_drdy", toPll[25], 1);
        prevDen = toPll[23];
        if (toPll[25]) rstmSeen = 1'b1;
        if (done) begin
            doneCount++;
            doneCyc  = cyc;
            doneErr  = error;
            doneCode = errCode;
            doneRstm = toPll[25];
        end
    end

    task automatic writeEntry(input int idx, input logic [6:0] a, input logic [15:0] d, input logic [15:0] m);
        @(negedge clk);
        cfgWr   = 1'b1;
        cfgIdx  = 3'(idx);
        cfgAddr = a;
        cfgData = d;
        cfgMask = m;
        @(negedge clk);
        cfgWr = 1'b0;
        tbAddr[idx] = a;
        tbData[idx] = d;
        tbMask[idx] = m;
    endtask

    task automatic applyStimulus(input int cnt, input int lat, input int drop);
        drpLatency = lat;
        dropTxn    = drop;
        txnLog.delete();
        memSnap    = mem;
        baseDone   = doneCount;
        rstmSeen   = 1'b0;
        @(negedge clk);
        start    = 1'b1;
        count    = 4'(cnt);
        startCyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (doneCount != baseDone) break;
            @(negedge clk);
        end
        checkOutput("done_seen", doneCount != baseDone, 1);
    endtask

    // Expected DRP traffic from the table and the memory as it stood at start.
    task automatic buildExpected(input int cnt);
        logic [15:0] m [128];
        txn_t        t;
        int          n;
        logic [15:0] v;
        m = memSnap;
        n = (cnt > DEPTH) ? DEPTH : cnt;
        expTxns.delete();
        for (int i = 0; i < n; i++) begin
            t.we = 1'b0; t.addr = tbAddr[i]; t.din = 16'h0;
            expTxns.push_back(t);
            v = (m[tbAddr[i]] & tbMask[i]) | (tbData[i] & ~tbMask[i]);
            m[tbAddr[i]] = v;
            t.we = 1'b1; t.din = v;
            expTxns.push_back(t);
        end
    endtask

    task automatic compareLog(input int limit);
        checkOutput("txn_count", txnLog.size(), limit);
        for (int i = 0; i < limit && i < txnLog.size() && i < expTxns.size(); i++) begin
            checkOutput($sformatf("txn%0d_we", i), txnLog[i].we, expTxns[i].we);
            checkOutput($sformatf("txn%0d_addr", i), txnLog[i].addr, expTxns[i].addr);
            if (expTxns[i].we) checkOutput($sformatf("txn%0d_din", i), txnLog[i].din, expTxns[i].din);
        end
    endtask

    task automatic checkDone(input int lat, input logic err, input logic [1:0] code);
        checkOutput("done_latency", doneCyc - startCyc, lat);
        checkOutput("done_error", doneErr, err);
        checkOutput("done_err_code", doneCode, code);
        checkOutput("done_rst_mmcm", doneRstm, 0);
    endtask

    initial begin
        rst = 1'b1; cfgWr = 1'b0; cfgIdx = '0; cfgAddr = '0; cfgData = '0;
        cfgMask = '0; start = 1'b0; count = '0;
        for (int i = 0; i < 128; i++) mem[i] = 16'(i * 16'h0123);
        mem[8'h08] = 16'hABCD;
        mem[8'h10] = 16'h1234;
        mem[8'h11] = 16'h9999;
        mem[8'h12] = 16'h4321;

        // Reset values.
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_error", error, 0);
        checkOutput("reset_err_code", errCode, 0);
        checkOutput("reset_drp_bus", toPll[25:0], 0);
        rst = 1'b0;

        // Single read-modify-write, 1-cycle drdy, already locked: 9 cycles.
        lockedBit = 1'b1;
        writeEntry(0, 7'h08, 16'h1234, 16'hF000);
        applyStimulus(1, 1, -1);
        checkOutput("rmw_busy", busy, 1);
        waitDone(100);
        checkDone(9, 0, 0);
        buildExpected(1);
        compareLog(2);
        if (txnLog.size() >= 2) begin
            checkOutput("rmw_read_addr", txnLog[0].addr, 7'h08);
            checkOutput("rmw_read_we", txnLog[0].we, 0);
            checkOutput("rmw_write_din", txnLog[1].din, 16'hA234);
        end

        // Three entries, drdy latency 3: 3*(2*3+3)+4 = 31 cycles.
        writeEntry(0, 7'h10, 16'h00FF, 16'hFF00);
        writeEntry(1, 7'h11, 16'h5A5A, 16'h0000);
        writeEntry(2, 7'h12, 16'hFFFF, 16'hFFFF);
        applyStimulus(3, 3, -1);
        waitDone(200);
        checkDone(31, 0, 0);
        buildExpected(3);
        compareLog(6);
        checkOutput("multi_mem_10", mem[8'h10], 16'h12FF);
        checkOutput("multi_mem_11", mem[8'h11], 16'h5A5A);
        checkOutput("multi_mem_12", mem[8'h12], 16'h4321);

        // count = 0: done on the next cycle, no DRP or reset activity.
        applyStimulus(0, 1, -1);
        waitDone(20);
        checkDone(1, 0, 0);
        checkOutput("zero_txns", txnLog.size(), 0);
        checkOutput("zero_rst_mmcm_seen", rstmSeen, 0);

        // No drdy for the second entry's read (txn 2): 3+5+20 = 28 cycles.
        applyStimulus(3, 1, 2);
        waitDone(200);
        checkDone(28, 1, 1);
        buildExpected(3);
        compareLog(3);
        checkOutput("timeout_third_untouched", mem[8'h12], memSnap[8'h12]);

        // Lock never arrives: 5+3+50 = 58 cycles, then a new start clears it.
        lockedBit = 1'b0;
        applyStimulus(1, 1, -1);
        waitDone(300);
        checkDone(58, 1, 2);
        checkOutput("lock_err_held", error, 1);
        lockedBit = 1'b1;
        applyStimulus(1, 1, -1);
        checkOutput("restart_clears_error", error, 0);
        checkOutput("restart_clears_code", errCode, 0);
        waitDone(100);
        checkDone(9, 0, 0);

        // Count above DEPTH is clamped: 8*(2+3)+4 = 44 cycles.
        for (int i = 3; i < DEPTH; i++) writeEntry(i, 7'(7'h20 + i), 16'(16'h1111 * i), 16'h0F0F);
        applyStimulus(15, 1, -1);
        waitDone(300);
        checkDone(44, 0, 0);
        buildExpected(15);
        compareLog(16);

        // Writes and starts while busy are ignored; rst during WAIT_WR aborts.
        applyStimulus(2, 6, -1);
        checkOutput("abort_busy", busy, 1);
        cfgWr = 1'b1; cfgIdx = 3'd0; cfgAddr = 7'h7F; cfgData = 16'hDEAD; cfgMask = 16'h0;
        start = 1'b1; count = 4'd0;
        @(negedge clk);
        cfgWr = 1'b0; start = 1'b0;
        for (int i = 0; i < 60 && txnLog.size() < 2; i++) @(posedge clk);
        checkOutput("abort_write_reached", txnLog.size() >= 2, 1);
        checkOutput("abort_no_restart_done", doneCount - baseDone, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_rst_mmcm", toPll[25], 0);
        checkOutput("abort_den", toPll[23], 0);
        checkOutput("abort_busy_low", busy, 0);
        checkOutput("abort_done_low", done, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("abort_no_done", doneCount - baseDone, 0);

        // Table must still hold the pre-abort entry 0.
        applyStimulus(1, 1, -1);
        waitDone(100);
        checkDone(9, 0, 0);
        buildExpected(1);
        compareLog(2);
        if (txnLog.size() >= 1) checkOutput("table_unchanged_addr", txnLog[0].addr, 7'h10);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
